// File: rtl/quan_sar_if.sv
// quan_sar_if: sample-in / code-out handshake bundle for the SAR quantizer.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the valid-ready handshake in each direction.
interface quan_sar_if #(
  parameter int IN_WIDTH   = 16,
  parameter int CODE_WIDTH = 4
);
  logic [IN_WIDTH-1:0]   in_sample;
  logic                  in_valid;
  logic                  in_ready;
  logic [CODE_WIDTH-1:0] out_code;
  logic                  out_valid;
  logic                  out_ready;

  // Quantizer side.
  modport slave (
    input  in_sample,
    input  in_valid,
    output in_ready,
    output out_code,
    output out_valid,
    input  out_ready
  );

  // Producer/consumer side.
  modport master (
    output in_sample,
    output in_valid,
    input  in_ready,
    input  out_code,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/quan_sar.sv
// quan_sar: 16-bit unsigned sample -> 4-bit code, largest k with sample >= B[k], by successive approximation.
// Latency: out_valid rises on the 4th edge after the accepting edge; at most one sample per 6 cycles.
// Backpressure: result held in DONE while out_ready=0; in_ready is high only in IDLE.
module quan_sar #(
  parameter int IN_WIDTH   = 16,
  parameter int CODE_WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  quan_sar_if.slave   bus,
  output logic        busy,
  output logic [15:0] sample_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   sample_q, sample_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic [1:0]            step_q, step_d;
  logic [15:0]           cnt_q, cnt_d;

  // Per-step search terms: the bit under test, the trial code and its boundary.
  logic [1:0]            bit_idx;
  logic [CODE_WIDTH-1:0] trial;
  logic [IN_WIDTH-1:0]   trial_bound;
  logic                  trial_hit;

  // Boundary table; B[0]=0 so every sample resolves to some code.
  function automatic logic [IN_WIDTH-1:0] boundary(input logic [CODE_WIDTH-1:0] idx);
    logic [IN_WIDTH-1:0] b;
    case (idx)
      4'd0:    b = 16'h0000;
      4'd1:    b = 16'h3AF9;
      4'd2:    b = 16'h51A8;
      4'd3:    b = 16'h6069;
      4'd4:    b = 16'h6BD7;
      4'd5:    b = 16'h74F2;
      4'd6:    b = 16'h7B04;
      4'd7:    b = 16'h7E7F;
      4'd8:    b = 16'h7FF7;
      4'd9:    b = 16'h8179;
      4'd10:   b = 16'h851C;
      4'd11:   b = 16'h8B7B;
      4'd12:   b = 16'h9511;
      4'd13:   b = 16'hA195;
      4'd14:   b = 16'hB2CE;
      default: b = 16'hC7CA;
    endcase
    return b;
  endfunction

  // MSB first: step 0 tests bit 3, step 3 tests bit 0. One lookup and one compare per cycle.
  assign bit_idx     = 2'd3 - step_q;
  assign trial       = code_q | (4'b0001 << bit_idx);
  assign trial_bound = boundary(trial);
  assign trial_hit   = (sample_q >= trial_bound);

  assign sample_cnt  = cnt_q;

  // State register and datapath registers; reset discards any sample in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      code_q   <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      code_q   <= code_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and handshake outputs; out_code is forced to 0 whenever out_valid is low.
  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    code_d        = code_q;
    step_d        = step_q;
    cnt_d         = cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_code  = '0;
    busy          = 1'b1;

    case (state_q)
      IDLE: begin
        busy         = 1'b0;
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          sample_d = bus.in_sample;
          code_d   = '0;
          step_d   = '0;
          state_d  = SEARCH;
        end
      end

      SEARCH: begin
        if (trial_hit) begin
          code_d = trial;
        end
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
        end
      end

      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_code  = code_q;
        if (bus.out_ready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
